// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Ports: clk, rst_n, div_valid/op/word, src1/src2, flush, ex_hold -> exe_stall_req, div_done, div_result.
module exe_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  input  logic [1:0]      div_op,
  input  logic            div_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            exe_stall_req,
  output logic            div_done,
  output logic [XLEN-1:0] div_result
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;
  localparam int RW = XLEN + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            rem_op_q;
  logic            word_q;

  function automatic logic [XLEN-1:0] sext_w(
    input logic [HW-1:0] x
  );
    return {{HW{x[HW-1]}}, x};
  endfunction

  logic            is_signed;
  logic            is_rem;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_val;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] sp_raw;
  logic [XLEN-1:0] sp_res;

  always_comb begin
    is_signed = ~div_op[0];
    is_rem    = div_op[1];
    a_ext     = src1;
    b_ext     = src2;
    min_val   = {1'b1, {(XLEN-1){1'b0}}};
    if (div_word) begin
      a_ext = is_signed ? sext_w(src1[HW-1:0])
                        : {{HW{1'b0}}, src1[HW-1:0]};
      b_ext = is_signed ? sext_w(src2[HW-1:0])
                        : {{HW{1'b0}}, src2[HW-1:0]};
      min_val = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = is_signed & (a_ext == min_val)
             & (b_ext == '1);
    if (div_zero)
      sp_raw = is_rem ? a_ext : '1;
    else
      sp_raw = is_rem ? '0 : a_ext;
    sp_res = div_word ? sext_w(sp_raw[HW-1:0]) : sp_raw;
  end

  // One restoring step: shift in the next dividend bit,
  // subtract the divisor if it fits, at full remainder width.
  logic [RW:0]     sh;
  logic            ge;
  logic [RW-1:0]   rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] fin_raw;
  logic [XLEN-1:0] fin_s;
  logic [XLEN-1:0] fin;

  always_comb begin
    sh      = {rem_q, quo_q[XLEN-1]};
    ge      = (sh >= {2'b00, dvs_q});
    rem_n   = ge ? RW'(sh - {2'b00, dvs_q}) : RW'(sh);
    quo_n   = {quo_q[XLEN-2:0], ge};
    fin_raw = rem_op_q ? rem_n[XLEN-1:0] : quo_n;
    fin_s   = (rem_op_q ? neg_r_q : neg_q_q)
            ? -fin_raw : fin_raw;
    fin     = word_q ? sext_w(fin_s[HW-1:0]) : fin_s;
  end

  assign exe_stall_req = rst_n & div_valid
                       & (state != DONE) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      rem_op_q   <= 1'b0;
      word_q     <= 1'b0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          div_done <= 1'b0;
          if (div_valid && !flush) begin
            rem_q    <= '0;
            quo_q    <= div_word ? {a_mag[HW-1:0], {HW{1'b0}}}
                                 : a_mag;
            dvs_q    <= b_mag;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            rem_op_q <= is_rem;
            word_q   <= div_word;
            if (div_zero || ovf) begin
              state      <= DONE;
              div_done   <= 1'b1;
              div_result <= sp_res;
            end else begin
              state <= CALC;
              cnt   <= div_word ? CW'(HW) : CW'(XLEN);
            end
          end
        end
        CALC: begin
          if (flush || !div_valid) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state      <= DONE;
              div_done   <= 1'b1;
              div_result <= fin;
            end
          end
        end
        DONE: begin
          if (flush || !ex_hold) begin
            state      <= IDLE;
            div_done   <= 1'b0;
            div_result <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          div_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: random and directed divides
// checked against an arithmetic reference model.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_valid = 1'b0;
  logic [1:0]  div_op = 2'd0;
  logic        div_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        ex_hold = 1'b0;
  logic        exe_stall_req;
  logic        div_done;
  logic [63:0] div_result;

  exe_div_unit #(.XLEN(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .div_valid(div_valid),
    .div_op(div_op),
    .div_word(div_word),
    .src1(src1),
    .src2(src2),
    .flush(flush),
    .ex_hold(ex_hold),
    .exe_stall_req(exe_stall_req),
    .div_done(div_done),
    .div_result(div_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stall_run = 0;
  logic done_q = 1'b0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic w,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    if (w) begin
      int          sa;
      int          sd;
      int unsigned ua;
      int unsigned ud;
      logic [31:0] r32;
      logic        ov;
      sa = a[31:0];
      sd = b[31:0];
      ua = a[31:0];
      ud = b[31:0];
      ov = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
      case (op)
        2'd0: if (ud == 0) r32 = 32'hFFFF_FFFF;
              else if (ov) r32 = a[31:0];
              else r32 = sa / sd;
        2'd1: if (ud == 0) r32 = 32'hFFFF_FFFF;
              else r32 = ua / ud;
        2'd2: if (ud == 0) r32 = a[31:0];
              else if (ov) r32 = 32'd0;
              else r32 = sa % sd;
        default: if (ud == 0) r32 = a[31:0];
                 else r32 = ua % ud;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      longint          sa;
      longint          sd;
      longint unsigned ua;
      longint unsigned ud;
      logic            ov;
      sa = a;
      sd = b;
      ua = a;
      ud = b;
      ov = (a == MIN64) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      case (op)
        2'd0: if (ud == 0) r = '1;
              else if (ov) r = a;
              else r = sa / sd;
        2'd1: if (ud == 0) r = '1;
              else r = ua / ud;
        2'd2: if (ud == 0) r = a;
              else if (ov) r = '0;
              else r = sa % sd;
        default: if (ud == 0) r = a;
                 else r = ua % ud;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_stalls(input logic [1:0] op,
                                    input logic w,
                                    input logic [63:0] a,
                                    input logic [63:0] b);
    logic zero;
    logic ov;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = !op[0] && (w ? (a[31:0] == 32'h8000_0000 &&
                         b[31:0] == 32'hFFFF_FFFF)
                      : (a == MIN64 && b == '1));
    if (zero || ov) return 1;
    return w ? 33 : 65;
  endfunction

  // Monitor: counts stall cycles and pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q = 1'b0;
    end else begin
      if (exe_stall_req) stall_run++;
      if (div_done && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", div_result, e.res);
          check("stall_len", 64'(stall_run), 64'(e.stalls));
          check("stall_at_done", {63'd0, exe_stall_req}, 64'd0);
        end
        stall_run = 0;
      end
      done_q = div_done;
    end
  end

  task automatic start_op(input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit push);
    div_valid = 1'b1;
    div_op    = op;
    div_word  = w;
    src1      = a;
    src2      = b;
    if (push)
      sb.push_back('{res: model(op, w, a, b),
                     stalls: exp_stalls(op, w, a, b)});
  endtask

  task automatic wait_done(input int hold, input logic [63:0] expres);
    int n;
    n = 0;
    while (!div_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!div_done) begin
      check("timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_back());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      ex_hold = 1'b1;
      @(posedge clk);
      #1;
      check("hold_done", {63'd0, div_done}, 64'd1);
      check("hold_result", div_result, expres);
    end
    ex_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input int hold);
    start_op(op, w, a, b, 1'b1);
    wait_done(hold, model(op, w, a, b));
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = MIN64;
      3: v = 64'h0000_0000_8000_0000;
      4: v = 64'($urandom_range(0, 20));
      5: v = {$urandom, $urandom} >> $urandom_range(0, 63);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {63'd0, exe_stall_req}, 64'd0);
    check("rst_done", {63'd0, div_done}, 64'd0);
    check("rst_result", div_result, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_stall", {63'd0, exe_stall_req}, 64'd0);

    run(2'd1, 1'b0, 64'd100, 64'd7, 0);
    run(2'd2, 1'b0, -64'sd7, 64'd2, 0);
    run(2'd3, 1'b1, 64'hFFFF_FFFF_0000_000B, 64'd3, 0);
    run(2'd0, 1'b0, 64'd5, 64'd0, 0);
    run(2'd0, 1'b1, 64'h8000_0000, '1, 0);
    run(2'd2, 1'b0, MIN64, '1, 0);
    div_valid = 1'b0;
    @(posedge clk);
    #1;

    // Flush in CALC cycle 10.
    start_op(2'd1, 1'b0, '1, 64'd3, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    div_valid = 1'b0;
    stall_run = 0;
    check("flush_stall", {63'd0, exe_stall_req}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("flush_nodone", {63'd0, div_done}, 64'd0);
      @(posedge clk);
      #1;
    end
    run(2'd1, 1'b0, 64'd1000, 64'd33, 0);

    // DONE held by ex_hold, then an immediate back-to-back DIV.
    run(2'd0, 1'b0, 64'd123456789, -64'sd321, 3);
    run(2'd0, 1'b0, -64'sd1000, 64'd7, 0);

    // Reset mid-CALC with div_valid held.
    start_op(2'd1, 1'b0, 64'd12345678, 64'd1234, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {63'd0, exe_stall_req}, 64'd0);
    check("mid_rst_done", {63'd0, div_done}, 64'd0);
    check("mid_rst_result", div_result, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_run = 0;
    start_op(2'd1, 1'b0, 64'd12345678, 64'd1234, 1'b1);
    wait_done(0, model(2'd1, 1'b0, 64'd12345678, 64'd1234));

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      run(op, w, a, b, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        div_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    div_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
